// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: opcode/funct fields, mul/div tracker state
// encoding and the register-match helper used by the hazard detector.
package hazard_stall_unit_pkg;

    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;

    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // $0 is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX/MEM hazard-relevant fields and the resulting pipeline controls.
interface hazard_stall_unit_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_is_branch;
    logic       id_branch_taken;
    logic       id_reads_hilo;
    logic       id_is_muldiv;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_muldiv_start;
    logic [4:0] mem_rd;
    logic       mem_mem_read;
    logic       mem_reg_write;

    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       muldiv_busy;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
               id_reads_hilo, id_is_muldiv, ex_rd, ex_reg_write, ex_mem_read,
               ex_muldiv_start, mem_rd, mem_mem_read, mem_reg_write,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
               id_reads_hilo, id_is_muldiv, ex_rd, ex_reg_write, ex_mem_read,
               ex_muldiv_start, mem_rd, mem_mem_read, mem_reg_write,
        output pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy
    );

endinterface

// File: rtl/hazard_stall_unit_muldiv_busy_tracker.sv
// HI/LO occupancy tracker: a down-counter armed when a mul/div leaves EX.
//   state | meaning
//   IDLE  | HI/LO results are available
//   BUSY  | mul/div in flight, busy_cnt cycles remaining
module muldiv_busy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [3:0] LAT = 4'(MULDIV_LAT);

    md_state_t  state, state_nxt;
    logic [3:0] busy_cnt, busy_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = BUSY;
                    busy_cnt_nxt = LAT;
                end
            end
            BUSY: begin
                // A new mul/div restarts the full latency instead of counting down.
                if (start) begin
                    busy_cnt_nxt = LAT;
                end else if (busy_cnt <= 4'd1) begin
                    state_nxt    = IDLE;
                    busy_cnt_nxt = 4'd0;
                end else begin
                    busy_cnt_nxt = busy_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                busy_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls for load-use, ID-resolved branches and
// HI/LO reads behind a busy mul/div; counts stall cycles with saturation.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_stall_unit_if.slave hz,
    output logic [CNT_W-1:0] stall_count
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic branch_haz;
    logic muldiv_haz;
    logic stall;
    logic md_busy;

    muldiv_busy_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (hz.ex_muldiv_start),
        .busy  (md_busy)
    );

    always_comb begin
        ex_match   = reg_match(hz.ex_rd,  hz.id_rs, hz.id_rt, hz.id_uses_rt);
        mem_match  = reg_match(hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt);
        load_use   = hz.ex_mem_read && hz.ex_reg_write && ex_match;
        // Branches compare in ID, so even an ALU result in EX is too late,
        // and a load still in MEM has not produced its data yet.
        branch_haz = hz.id_is_branch &&
                     ((hz.ex_reg_write && ex_match) ||
                      (hz.mem_mem_read && hz.mem_reg_write && mem_match));
        muldiv_haz = (hz.id_reads_hilo || hz.id_is_muldiv) &&
                     (md_busy || hz.ex_muldiv_start);
        stall      = load_use || branch_haz || muldiv_haz;
    end

    assign hz.pc_write    = ~stall;
    assign hz.ifid_write  = ~stall;
    assign hz.idex_bubble = stall;
    assign hz.ifid_flush  = hz.id_branch_taken && ~stall;
    assign hz.muldiv_busy = md_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance plus a small one
// (MULDIV_LAT=1, CNT_W=2) sharing the same stimulus.
module tb_hazard_stall_unit;

    logic clk;
    logic rst_n;
    logic [31:0] cnt1_ext;
    int checks = 0;
    int errors = 0;

    hazard_stall_unit_if hz ();
    hazard_stall_unit_if hz1 ();
    logic [31:0] stall_count;
    logic [1:0]  stall_count1;

    hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk (clk), .rst_n (rst_n), .hz (hz.slave), .stall_count (stall_count)
    );

    hazard_stall_unit #(.MULDIV_LAT(1), .CNT_W(2)) dut1 (
        .clk (clk), .rst_n (rst_n), .hz (hz1.slave), .stall_count (stall_count1)
    );

    assign hz1.id_rs           = hz.id_rs;
    assign hz1.id_rt           = hz.id_rt;
    assign hz1.id_uses_rt      = hz.id_uses_rt;
    assign hz1.id_is_branch    = hz.id_is_branch;
    assign hz1.id_branch_taken = hz.id_branch_taken;
    assign hz1.id_reads_hilo   = hz.id_reads_hilo;
    assign hz1.id_is_muldiv    = hz.id_is_muldiv;
    assign hz1.ex_rd           = hz.ex_rd;
    assign hz1.ex_reg_write    = hz.ex_reg_write;
    assign hz1.ex_mem_read     = hz.ex_mem_read;
    assign hz1.ex_muldiv_start = hz.ex_muldiv_start;
    assign hz1.mem_rd          = hz.mem_rd;
    assign hz1.mem_mem_read    = hz.mem_mem_read;
    assign hz1.mem_reg_write   = hz.mem_reg_write;
    assign cnt1_ext            = {30'd0, stall_count1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.id_rs = 5'd0;           hz.id_rt = 5'd0;
        hz.id_uses_rt = 1'b0;      hz.id_is_branch = 1'b0;
        hz.id_branch_taken = 1'b0; hz.id_reads_hilo = 1'b0;
        hz.id_is_muldiv = 1'b0;    hz.ex_rd = 5'd0;
        hz.ex_reg_write = 1'b0;    hz.ex_mem_read = 1'b0;
        hz.ex_muldiv_start = 1'b0; hz.mem_rd = 5'd0;
        hz.mem_mem_read = 1'b0;    hz.mem_reg_write = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp_stall);
        chk({tag, "_pcw"},    {31'd0, hz.pc_write},    {31'd0, ~exp_stall});
        chk({tag, "_ifidw"},  {31'd0, hz.ifid_write},  {31'd0, ~exp_stall});
        chk({tag, "_bubble"}, {31'd0, hz.idex_bubble}, {31'd0, exp_stall});
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk_stall("rst", 1'b0);
        chk("rst_flush", {31'd0, hz.ifid_flush}, 32'd0);
        chk("rst_busy",  {31'd0, hz.muldiv_busy}, 32'd0);
        chk("rst_cnt",   stall_count, 32'd0);
        #9 rst_n = 1'b1;

        // Load-use on rs
        step();
        hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8;
        #1 chk_stall("lu", 1'b1);
        step();
        clear_inputs();
        hz.id_rs = 5'd8;
        hz.mem_mem_read = 1'b1; hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd8;
        #1 chk_stall("lu_rel", 1'b0);
        chk("lu_cnt", stall_count, 32'd1);

        // Register $0 never hazards
        step();
        clear_inputs();
        hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_rd = 5'd0;
        hz.id_uses_rt = 1'b1; hz.id_is_branch = 1'b1;
        #1 chk_stall("r0", 1'b0);
        step();
        chk("r0_cnt", stall_count, 32'd1);

        // Branch after load: two stall cycles, then flush on resolution
        clear_inputs();
        hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_rd = 5'd9;
        hz.id_is_branch = 1'b1; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd9; hz.id_rs = 5'd3;
        hz.id_branch_taken = 1'b1;
        #1 chk_stall("bl1", 1'b1);
        chk("bl1_flush", {31'd0, hz.ifid_flush}, 32'd0);
        step();
        hz.ex_mem_read = 1'b0; hz.ex_reg_write = 1'b0; hz.ex_rd = 5'd0;
        hz.mem_mem_read = 1'b1; hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd9;
        #1 chk_stall("bl2", 1'b1);
        chk("bl2_flush", {31'd0, hz.ifid_flush}, 32'd0);
        step();
        hz.mem_mem_read = 1'b0; hz.mem_reg_write = 1'b0; hz.mem_rd = 5'd0;
        #1 chk_stall("bl3", 1'b0);
        chk("bl3_flush", {31'd0, hz.ifid_flush}, 32'd1);
        chk("bl_cnt", stall_count, 32'd3);

        // Branch after ALU write: one stall cycle
        step();
        clear_inputs();
        hz.ex_reg_write = 1'b1; hz.ex_rd = 5'd4; hz.id_is_branch = 1'b1; hz.id_rs = 5'd4;
        #1 chk_stall("ba1", 1'b1);
        step();
        clear_inputs();
        hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd4; hz.id_is_branch = 1'b1; hz.id_rs = 5'd4;
        #1 chk_stall("ba2", 1'b0);
        chk("ba_cnt", stall_count, 32'd4);
        chk("sat_cnt1", cnt1_ext, 32'd3);

        // Mul/div occupancy with mflo held in ID
        step();
        clear_inputs();
        hz.ex_muldiv_start = 1'b1; hz.id_reads_hilo = 1'b1;
        #1 chk_stall("md0", 1'b1);
        chk("md0_busy", {31'd0, hz.muldiv_busy}, 32'd0);
        step();
        hz.ex_muldiv_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("md_busy", {31'd0, hz.muldiv_busy}, 32'd1);
            chk("md_bub", {31'd0, hz.idex_bubble}, 32'd1);
            chk("md1_busy", {31'd0, hz1.muldiv_busy}, (i == 0) ? 32'd1 : 32'd0);
            step();
        end
        #1 chk("md_done_busy", {31'd0, hz.muldiv_busy}, 32'd0);
        chk_stall("md_done", 1'b0);
        chk("md_cnt", stall_count, 32'd9);
        chk("md_cnt1", cnt1_ext, 32'd3);

        // Restart while busy_cnt=2 reloads the full latency
        step();
        clear_inputs();
        hz.ex_muldiv_start = 1'b1;
        step();
        hz.ex_muldiv_start = 1'b0;
        step();
        step();
        hz.ex_muldiv_start = 1'b1;
        step();
        hz.ex_muldiv_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rs_busy", {31'd0, hz.muldiv_busy}, 32'd1);
            step();
        end
        #1 chk("rs_done", {31'd0, hz.muldiv_busy}, 32'd0);
        chk("rs_cnt", stall_count, 32'd9);

        // Reset mid-BUSY
        step();
        hz.ex_muldiv_start = 1'b1;
        step();
        hz.ex_muldiv_start = 1'b0;
        step();
        rst_n = 1'b0;
        #1 chk("rb_busy", {31'd0, hz.muldiv_busy}, 32'd0);
        chk("rb_cnt", stall_count, 32'd0);
        chk("rb_cnt1", cnt1_ext, 32'd0);
        rst_n = 1'b1;
        hz.id_reads_hilo = 1'b1;
        #1 chk_stall("rb_mfhi", 1'b0);
        step();
        chk("rb_busy2", {31'd0, hz.muldiv_busy}, 32'd0);
        chk("rb_cnt2", stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
